// File: rtl/trng_entropy_collector.sv
// trng_entropy_collector
//   Collects a serial raw-entropy stream into a TRNG_A_WIDTH+TRNG_D_WIDTH
//   shift buffer. It enforces a minimum refresh interval, then emits a
//   one-cycle dcr strobe with the packed trng_a/trng_d words.
//
//   Optional feature macro: TRNG_HEALTH_TEST_EN
//     When defined, a repetition-count health test drops any buffer in which
//     REP_LIMIT identical bits arrive in a row, and raises a sticky
//     health_fail flag. When undefined, health_fail is tied low.
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   ent_valid    ent_bit is valid this cycle
//   ent_bit      raw entropy bit (shifted into the buffer LSB)
//   refresh_req  early refresh request, bypasses the interval timer
//   dcr          registered one-cycle load strobe
//   trng_a       packed upper word (first collected bit is its MSB)
//   trng_d       packed lower word
//   ready        buffer full, waiting for the refresh condition
//   health_fail  sticky repetition-test failure flag
module trng_entropy_collector #(
  parameter int TRNG_A_WIDTH   = 64,
  parameter int TRNG_D_WIDTH   = 32,
  parameter int REFRESH_CYCLES = 1024,
  parameter int REP_LIMIT      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ent_valid,
  input  logic                    ent_bit,
  input  logic                    refresh_req,
  output logic                    dcr,
  output logic [TRNG_A_WIDTH-1:0] trng_a,
  output logic [TRNG_D_WIDTH-1:0] trng_d,
  output logic                    ready,
  output logic                    health_fail
);

  localparam int N  = TRNG_A_WIDTH + TRNG_D_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(REFRESH_CYCLES);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [TW-1:0] TMR_MAX  = TW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [N-1:0]    sr;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   timer;
  logic            req_pend;
  logic            timer_done;
  logic            accept;
  logic            refresh_hit;
  logic            discard;
  logic            issue_go;
  logic            dcr_next;
  logic            ready_next;

  assign timer_done  = (timer == TMR_MAX);
  assign accept      = (state == COLLECT) && ent_valid;
  assign refresh_hit = timer_done || req_pend || refresh_req;

`ifdef TRNG_HEALTH_TEST_EN
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_next;
  logic          rep_bit;
  logic          hf_q;

  // A zero run count marks "no previous bit" (after reset or a discard),
  // so the next accepted bit always starts a fresh run of one.
  always_comb begin
    rep_next = RW'(1);
    if ((rep_cnt != '0) && (ent_bit == rep_bit))
      rep_next = rep_cnt + RW'(1);
  end

  assign discard = accept && (rep_next == REP_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
      rep_bit <= 1'b0;
      hf_q    <= 1'b0;
    end else if (accept) begin
      rep_bit <= ent_bit;
      if (discard) begin
        rep_cnt <= '0;
        hf_q    <= 1'b1;
      end else begin
        rep_cnt <= rep_next;
      end
    end
  end

  assign health_fail = hf_q;
`else
  assign discard     = 1'b0;
  assign health_fail = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (accept && !discard && (cnt == CNT_LAST)) next_state = WAIT;
      WAIT:    if (refresh_hit)                              next_state = ISSUE;
      ISSUE:   next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  // Output decode; dcr/ready are registered from the next state so they are
  // clean flop outputs aligned with the ISSUE/WAIT cycles.
  always_comb begin
    issue_go   = (state == WAIT) && (next_state == ISSUE);
    dcr_next   = (next_state == ISSUE);
    ready_next = (next_state == WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcr    <= 1'b0;
      ready  <= 1'b0;
      trng_a <= '0;
      trng_d <= '0;
    end else begin
      dcr   <= dcr_next;
      ready <= ready_next;
      if (issue_go) begin
        trng_a <= sr[N-1:TRNG_D_WIDTH];
        trng_d <= sr[TRNG_D_WIDTH-1:0];
      end
    end
  end

  // Collection buffer and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      if (accept)
        sr <= discard ? '0 : {sr[N-2:0], ent_bit};
      if (state == ISSUE)
        cnt <= '0;
      else if (accept)
        cnt <= discard ? '0 : cnt + CW'(1);
    end
  end

  // Interval timer. It is zeroed on the edge into ISSUE and again on the
  // edge leaving it, so two timer-limited pulses sit REFRESH_CYCLES+1 apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      timer <= '0;
    else if (issue_go || (state == ISSUE))
      timer <= '0;
    else if (!timer_done)
      timer <= timer + TW'(1);
  end

  // Early-refresh latch: remembers a request made before the buffer filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      req_pend <= 1'b0;
    else if (issue_go)
      req_pend <= 1'b0;
    else if ((state == COLLECT) && refresh_req)
      req_pend <= 1'b1;
  end

endmodule

// File: tb/tb_trng_entropy_collector.sv
module tb_trng_entropy_collector;

  localparam int AW   = 64;
  localparam int DW   = 32;
  localparam int N    = AW + DW;
  localparam int RC   = 16;
  localparam int RC_L = 1024;
  localparam int RL   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ent_valid = 1'b0;
  logic ent_bit = 1'b0;
  logic refresh_req = 1'b0;

  logic          dcr, ready, health_fail;
  logic [AW-1:0] trng_a;
  logic [DW-1:0] trng_d;

  logic          dcr_l, ready_l, hf_l;
  logic [AW-1:0] a_l;
  logic [DW-1:0] d_l;

  trng_entropy_collector #(
    .TRNG_A_WIDTH(AW), .TRNG_D_WIDTH(DW), .REFRESH_CYCLES(RC), .REP_LIMIT(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ent_valid(ent_valid), .ent_bit(ent_bit),
    .refresh_req(refresh_req), .dcr(dcr), .trng_a(trng_a), .trng_d(trng_d),
    .ready(ready), .health_fail(health_fail)
  );

  trng_entropy_collector #(
    .TRNG_A_WIDTH(AW), .TRNG_D_WIDTH(DW), .REFRESH_CYCLES(RC_L), .REP_LIMIT(RL)
  ) dut_l (
    .clk(clk), .rst_n(rst_n), .ent_valid(ent_valid), .ent_bit(ent_bit),
    .refresh_req(refresh_req), .dcr(dcr_l), .trng_a(a_l), .trng_d(d_l),
    .ready(ready_l), .health_fail(hf_l)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   last_dcr = -1;
  logic dcr_prev = 1'b0;
  int   n_dcr = 0;
  int   l_cnt = 0;
  int   l_cyc = 0;

  // Scoreboard monitor for the short-interval instance.
  always @(negedge clk) begin
    if (!rst_n) last_dcr = -1;
    if (dcr) begin
      n_dcr++;
      check("dcr_one_cycle", dcr_prev, 1'b0);
      if (sb.size() == 0) begin
        check("dcr_unexpected", dcr, 1'b0);
      end else begin
        e_mon = sb.pop_front();
        check("dcr_trng_a", trng_a, e_mon.a);
        check("dcr_trng_d", trng_d, e_mon.d);
        check("dcr_cycle", cyc, e_mon.cyc);
      end
      if (last_dcr >= 0) check("dcr_gap", (cyc - last_dcr) >= (RC + 1), 1'b1);
      last_dcr = cyc;
    end
    dcr_prev = dcr;
    if (dcr_l) begin
      l_cnt++;
      l_cyc = cyc;
    end
  end

  function automatic logic [N-1:0] rl_rand();
    logic [N-1:0] v;
    int           run;
    logic         prev;
    v    = {$urandom, $urandom, $urandom};
    run  = 0;
    prev = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (run > 0 && v[i] == prev) begin
        if (run == 3) begin
          v[i] = ~prev;
          run  = 1;
        end else begin
          run++;
        end
      end else begin
        run = 1;
      end
      prev = v[i];
    end
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ent_valid = 1'b0; refresh_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic b, input logic rq);
    @(negedge clk);
    ent_valid = 1'b1; ent_bit = b; refresh_req = rq;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ent_valid = 1'b0; refresh_req = 1'b0;
    end
  endtask

  task automatic feed_buf(input logic [N-1:0] data, input int rq_idx, output int last_cyc);
    exp_t e;
    for (int i = 0; i < N; i++) drive(data[N-1-i], i == rq_idx);
    last_cyc = cyc;
    e.a = data[N-1:DW];
    e.d = data[DW-1:0];
    e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  // WAIT then ISSUE with junk bits on ent_valid, which must be ignored.
  task automatic post_full();
    @(negedge clk);
    check("ready_in_wait", ready, 1'b1);
    check("no_dcr_in_wait", dcr, 1'b0);
    ent_valid = 1'b1; ent_bit = 1'($urandom); refresh_req = 1'b0;
    @(negedge clk);
    check("ready_in_issue", ready, 1'b0);
    ent_bit = 1'($urandom);
  endtask

  logic [N-1:0] r1, r2, r3, r4;
  logic         s [124];
  int           lc, lc1, l_first, base, target;

  initial begin
    // Reset and idle
    do_reset();
    idle(20);
    check("rst_dcr", dcr, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_trng_a", trng_a, '0);
    check("rst_trng_d", trng_d, '0);
    check("rst_health", health_fail, 1'b0);

    // 0xA5 pattern, timer already expired
    feed_buf(96'hA5A5A5A5A5A5A5A5A5A5A5A5, -1, lc);
    post_full();
    idle(3);
    check("a5_trng_a", trng_a, 64'hA5A5A5A5A5A5A5A5);
    check("a5_trng_d", trng_d, 32'hA5A5A5A5);

    // Back-to-back buffers with ent_valid held high
    r1 = rl_rand();
    r2 = rl_rand();
    feed_buf(r1, -1, lc);
    post_full();
    feed_buf(r2, -1, lc);
    check("hold_trng_a", trng_a, r1[N-1:DW]);
    check("hold_trng_d", trng_d, r1[DW-1:0]);
    post_full();
    idle(3);
    check("b2b_sb_empty", sb.size(), 0);

    // Early refresh on the long-interval instance
    do_reset();
    base = l_cnt;
    r1 = rl_rand();
    r2 = rl_rand();
    feed_buf(r1, 10, lc1);
    post_full();
    idle(1);
    check("req_l_count1", l_cnt - base, 1);
    check("req_l_cycle1", l_cyc, lc1 + 2);
    check("req_l_trng_a1", a_l, r1[N-1:DW]);
    check("req_l_trng_d1", d_l, r1[DW-1:0]);
    l_first = l_cyc;
    feed_buf(r2, -1, lc);
    post_full();
    target = l_first + RC_L - 5;
    while (cyc < target) idle(1);
    check("req_l_ready_wait", ready_l, 1'b1);
    check("req_l_count_wait", l_cnt - base, 1);
    check("req_l_hold_a", a_l, r1[N-1:DW]);
    target = l_first + RC_L + 5;
    while (cyc < target) idle(1);
    check("req_l_count2", l_cnt - base, 2);
    check("req_l_cycle2", l_cyc, l_first + RC_L + 1);
    check("req_l_trng_a2", a_l, r2[N-1:DW]);
    check("req_l_trng_d2", d_l, r2[DW-1:0]);
    check("req_l_ready_after", ready_l, 1'b0);
    check("req_sb_empty", sb.size(), 0);

    // Health test stimulus: 20 alternating, 8 ones, 96 alternating
    do_reset();
    for (int i = 0; i < 20; i++) s[i] = (i % 2 == 0);
    for (int i = 20; i < 28; i++) s[i] = 1'b1;
    for (int i = 28; i < 124; i++) s[i] = ((i - 28) % 2 == 0);
    base = n_dcr;
`ifdef TRNG_HEALTH_TEST_EN
    for (int i = 0; i < 28; i++) drive(s[i], 1'b0);
    idle(3);
    check("hf_set", health_fail, 1'b1);
    check("hf_no_dcr", n_dcr - base, 0);
    feed_buf({48{2'b10}}, -1, lc);
    post_full();
    idle(3);
    check("hf_trng_a", trng_a, 64'hAAAAAAAAAAAAAAAA);
    check("hf_trng_d", trng_d, 32'hAAAAAAAA);
    check("hf_sticky", health_fail, 1'b1);
`else
    r3 = '0;
    for (int i = 0; i < 124; i++) begin
      drive(s[i], 1'b0);
      if (i < N) r3 = {r3[N-2:0], s[i]};
      if (i == N - 1) begin
        exp_t e;
        e.a = r3[N-1:DW];
        e.d = r3[DW-1:0];
        e.cyc = cyc + 2;
        sb.push_back(e);
      end
    end
    idle(3);
    check("nohf_flag", health_fail, 1'b0);
    check("nohf_dcr_count", n_dcr - base, 1);
    check("nohf_trng_a", trng_a, r3[N-1:DW]);
`endif
    check("hf_sb_empty", sb.size(), 0);

    // Reset in the middle of a buffer
    do_reset();
    check("rst2_health", health_fail, 1'b0);
    r3 = rl_rand();
    feed_buf(r3, -1, lc);
    post_full();
    for (int i = 0; i < 50; i++) drive(1'($urandom), 1'b0);
    @(negedge clk);
    rst_n = 1'b0; ent_valid = 1'b0;
    #1;
    check("mid_rst_dcr", dcr, 1'b0);
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_trng_a", trng_a, '0);
    check("mid_rst_trng_d", trng_d, '0);
    check("mid_rst_health", health_fail, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = n_dcr;
    r4 = rl_rand();
    for (int i = 0; i < N - 1; i++) drive(r4[N-1-i], 1'b0);
    idle(30);
    check("partial_no_dcr", n_dcr - base, 0);
    check("partial_ready", ready, 1'b0);
    drive(r4[0], 1'b0);
    begin
      exp_t e;
      e.a = r4[N-1:DW];
      e.d = r4[DW-1:0];
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    idle(5);
    check("post_rst_dcr_count", n_dcr - base, 1);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trng_entropy_collector.md
# trng_entropy_collector

Upstream stage of the TRNG register manager. Collects a serial stream of raw entropy bits into a TRNG_A_WIDTH+TRNG_D_WIDTH buffer. Enforces a minimum refresh interval, then issues a single-cycle `dcr` strobe with the packed `trng_a`/`trng_d` words for the register manager to load. An optional repetition-count health test discards buffers built from a stuck source.

## Interface
- TRNG_A_WIDTH, 64, width of `trng_a`
- TRNG_D_WIDTH, 32, width of `trng_d`
- REFRESH_CYCLES, 1024, minimum clk cycles between `dcr` pulses (≥2)
- REP_LIMIT, 32, run length of identical bits that fails the health test (≥2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ent_valid  in  1  `ent_bit` valid this cycle
- ent_bit  in  1  raw entropy bit
- refresh_req  in  1  request early refresh; bypasses interval timer
- dcr  out  1  registered single-cycle load strobe to the register manager
- trng_a  out  TRNG_A_WIDTH  packed upper word
- trng_d  out  TRNG_D_WIDTH  packed lower word
- ready  out  1  buffer full, waiting for refresh condition (high in WAIT)
- health_fail  out  1  sticky health-test failure flag

## Operation
- N = TRNG_A_WIDTH+TRNG_D_WIDTH. Buffer `sr[N-1:0]` shifts left; each new bit enters the LSB.
- Bit counter width is $clog2(N+1). Timer width is $clog2(REFRESH_CYCLES).
- States: COLLECT, WAIT, ISSUE.
- COLLECT:
  - Each cycle with `ent_valid=1`, shift in `ent_bit` and increment the count.
  - On acceptance of the Nth bit, go to WAIT.
- WAIT:
  - `ent_valid` is ignored.
  - When `timer_done || req_pend || refresh_req`, go to ISSUE.
- ISSUE (one cycle):
  - `dcr=1`.
  - `trng_a = sr[N-1:TRNG_D_WIDTH]`, `trng_d = sr[TRNG_D_WIDTH-1:0]`. The first collected bit lands in the `trng_a` MSB.
  - Clear count and timer; clear `req_pend`; return to COLLECT.
  - `ent_valid` is ignored during ISSUE.
- Timer:
  - Increments every cycle in every state.
  - Saturates at REFRESH_CYCLES-1; `timer_done` = saturated.
  - Cleared on the edge entering ISSUE. Starts from 0 at reset.
- `req_pend`:
  - Set when `refresh_req=1` in COLLECT, so a request that arrives before the buffer is full is not lost.
  - Cleared on entering ISSUE. `refresh_req` during ISSUE is dropped.
- `trng_a`/`trng_d` are updated only on entering ISSUE and hold their values otherwise.
- Reset values: state COLLECT; `dcr`, `ready`, `health_fail` = 0; `trng_a`, `trng_d`, `sr`, count, timer, `req_pend` = 0.
- Reset mid-operation discards a partial buffer. No `dcr` is produced across reset.

## Timing
- `dcr` is high for exactly one cycle; `trng_a`/`trng_d` are valid in that same cycle.
- Latency: the Nth bit is accepted at edge k. If the refresh condition is already true, WAIT lasts one cycle and `dcr` is high in the cycle after edge k+1.
- Minimum `dcr` spacing with no `refresh_req`: REFRESH_CYCLES+1 cycles, first pulse to second pulse.
- Maximum `dcr` rate with a continuous `ent_valid` and `refresh_req` held high: one pulse per N+2 cycles.
- `ready` is high during WAIT only.

## Configuration
- Macro: `TRNG_HEALTH_TEST_EN`.
- Defined:
  - A repetition counter tracks the run of identical bits accepted in COLLECT; the first bit after a discard starts a run of 1.
  - When the run length reaches REP_LIMIT on an accepted bit: set `health_fail` (sticky until reset), discard the buffer (count=0, `sr`=0), reset the run, and stay in COLLECT.
  - The timer and `req_pend` are unaffected.
- Undefined:
  - No repetition counter.
  - `health_fail` is tied to 0.
  - All collected buffers are issued.

## Test plan
(Bench parameters: REFRESH_CYCLES=16, REP_LIMIT=8, default widths.)
- Reset then idle 20 cycles -> `dcr`=0, `ready`=0, `trng_a`=0, `trng_d`=0, `health_fail`=0.
- Feed 96 bits of the pattern 0xA5A5… continuously at t=0; the timer expires before the 96th bit -> single `dcr` one cycle after acceptance; `trng_a`=0xA5A5A5A5A5A5A5A5, `trng_d`=0xA5A5A5A5.
- Two full buffers back to back with `ent_valid` high and `refresh_req`=0 -> second `dcr` not before 17 cycles after the first; `ready` is high while waiting; outputs hold between pulses.
- Pulse `refresh_req` once during COLLECT (bit 10), set REFRESH_CYCLES=1024 -> `dcr` follows the 96th bit without waiting for the timer; a second buffer without a request waits 1024 cycles.
- With `TRNG_HEALTH_TEST_EN`, feed 8 consecutive 1s after 20 alternating bits -> `health_fail`=1, no `dcr`; the next 96 alternating bits produce `dcr` with `trng_a`=0xAAAAAAAAAAAAAAAA (starting with 1). Without the macro, the same stimulus issues a buffer and `health_fail` stays 0.
- Assert `rst_n` low at bit 50 -> all outputs 0; after release, 96 new bits are required before `dcr`.
